// File: rtl/mod_p_reduce_pkg.sv
// Shared constants for the modular reducer: field prime, inverter exponent,
// datapath widths and FSM state encoding.
package mod_p_reduce_pkg;
  localparam int W_RES = 64;
  localparam int W_REM = 65;
  localparam int W_IN  = 128;
  localparam int W_CNT = 7;

  localparam logic [W_RES-1:0] P_MOD_DEF = 64'd10997031918897188677;
  localparam logic [W_RES-1:0] INV_EXP   = P_MOD_DEF - 64'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;
endpackage

// File: rtl/mod_p_step.sv
// One restoring reduction step: shift in the next operand bit, then subtract
// P_MOD once if the shifted remainder reached it.
module mod_p_step
  import mod_p_reduce_pkg::*;
#(
  parameter logic [W_RES-1:0] P_MOD = P_MOD_DEF
) (
  input  logic [W_REM-1:0] r_in,
  input  logic             bit_in,
  output logic [W_REM-1:0] r_out
);
  logic [W_REM-1:0] shifted;
  logic             ge;

  // r_in < P_MOD < 2^64, so r_in[64] is always 0; folding it into the compare
  // keeps the step safe even if that invariant were ever broken.
  always_comb begin
    shifted = {r_in[W_REM-2:0], bit_in};
    ge      = r_in[W_REM-1] | (shifted >= {1'b0, P_MOD});
    r_out   = ge ? (shifted - {1'b0, P_MOD}) : shifted;
  end
endmodule

// File: rtl/mod_p_reduce.sv
// Sequential reduction of a signed-magnitude 128-bit operand modulo P_MOD,
// one bit per cycle MSB first, with a final sign fix-up.
module mod_p_reduce
  import mod_p_reduce_pkg::*;
#(
  parameter logic [W_RES-1:0] P_MOD = P_MOD_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [W_IN-1:0]   mod_input,
  input  logic              mod_input_sign,
  output logic              mod_done,
  output logic [W_RES-1:0]  mod_result,
  output logic              busy
);
  state_e           state_q, state_d;
  logic [W_CNT-1:0] cnt_q, cnt_d;
  logic [W_REM-1:0] r_q, r_d, r_step;
  logic [W_IN-1:0]  op_q, op_d;
  logic             sign_q, sign_d;
  logic [W_RES-1:0] res_q, res_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  mod_p_step #(.P_MOD(P_MOD)) u_step (
    .r_in  (r_q),
    .bit_in(op_q[cnt_q]),
    .r_out (r_step)
  );

  // A fresh enable wins in every state, aborting whatever was in flight.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    op_d    = op_q;
    sign_d  = sign_q;
    res_d   = res_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    if (enable) begin
      state_d = S_RUN;
      cnt_d   = '1;
      r_d     = '0;
      op_d    = mod_input;
      sign_d  = mod_input_sign;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        S_RUN: begin
          r_d = r_step;
          if (cnt_q == '0) state_d = S_FIX;
          else             cnt_d   = cnt_q - 1'b1;
        end
        S_FIX: begin
          res_d   = (sign_q && (r_q != '0)) ? (P_MOD - r_q[W_RES-1:0]) : r_q[W_RES-1:0];
          done_d  = 1'b1;
          state_d = S_DONE;
        end
        S_DONE: begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      res_q   <= res_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign mod_done   = done_q;
  assign mod_result = res_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_mod_p_reduce.sv
// Directed and randomized checks of mod_p_reduce: residues, latency, abort,
// mid-run reset and back-to-back starts.
module tb_mod_p_reduce;
  localparam logic [63:0] P = 64'd10997031918897188677;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic [127:0] mod_input = '0;
  logic         mod_input_sign = 1'b0;
  logic         mod_done;
  logic [63:0]  mod_result;
  logic         busy;

  int checks = 0;
  int errors = 0;

  mod_p_reduce dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .mod_input     (mod_input),
    .mod_input_sign(mod_input_sign),
    .mod_done      (mod_done),
    .mod_result    (mod_result),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mod(input logic [127:0] op, input logic sg);
    logic [127:0] m;
    m = op % {64'd0, P};
    if (sg && (m != 0)) return P - m[63:0];
    return m[63:0];
  endfunction

  // Call at a negedge; enable is sampled on the following posedge, after
  // which the inputs are scrambled to prove they were latched.
  task automatic start(input logic [127:0] op, input logic sg);
    enable = 1'b1; mod_input = op; mod_input_sign = sg;
    @(posedge clk); #1;
    enable = 1'b0; mod_input = ~op; mod_input_sign = ~sg;
  endtask

  // Returns at the negedge of the done cycle; lat counts cycles after enable.
  task automatic wait_done(output int lat, output logic [63:0] res);
    lat = 0; res = '0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (mod_done) begin lat = n; res = mod_result; break; end
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (mod_done !== 1'b0 || mod_result !== 64'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: done=%b result=%0d busy=%b, required 0/0/0", mod_done, mod_result, busy);
    end
    #20 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [127:0] ops [7];
    logic         sgs [7];
    logic [63:0]  exp [7];
    logic [127:0] pm1;
    logic [63:0]  res;
    int           lat;
    pm1 = {64'd0, P - 64'd1};
    ops[0] = 128'd0;                       sgs[0] = 1'b0; exp[0] = 64'd0;
    ops[1] = {64'd0, P} + 128'd5;          sgs[1] = 1'b0; exp[1] = 64'd5;
    ops[2] = 128'd5;                       sgs[2] = 1'b1; exp[2] = P - 64'd5;
    ops[3] = {64'd0, P};                   sgs[3] = 1'b1; exp[3] = 64'd0;
    ops[4] = pm1 * pm1;                    sgs[4] = 1'b0; exp[4] = 64'd1;
    ops[5] = {P, 64'd0} + 128'd3;          sgs[5] = 1'b0; exp[5] = 64'd3;
    ops[6] = {64'd0, P - 64'd1};           sgs[6] = 1'b1; exp[6] = 64'd1;
    for (int i = 0; i < 7; i++) begin
      start(ops[i], sgs[i]);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_start[%0d]: busy=%b, required 1", i, busy); end
      wait_done(lat, res);
      checks++;
      if (lat != 130) begin errors++; $display("FAIL latency[%0d]: %0d cycles, required 130", i, lat); end
      checks++;
      if (res !== exp[i]) begin errors++; $display("FAIL result[%0d]: %0d, required %0d", i, res, exp[i]); end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_done[%0d]: busy=%b, required 1", i, busy); end
      @(negedge clk);
      checks++;
      if (mod_done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL after_done[%0d]: done=%b busy=%b, required 0/0", i, mod_done, busy);
      end
      checks++;
      if (mod_result !== exp[i]) begin errors++; $display("FAIL hold[%0d]: %0d, required %0d", i, mod_result, exp[i]); end
    end
    start({128{1'b1}}, 1'b0);
    wait_done(lat, res);
    checks++;
    if (res !== ref_mod({128{1'b1}}, 1'b0) || lat != 130) begin
      errors++; $display("FAIL all_ones: %0d lat %0d, required %0d lat 130", res, lat, ref_mod({128{1'b1}}, 1'b0));
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [127:0] op;
    logic         sg;
    logic [63:0]  res;
    int           lat;
    for (int i = 0; i < 150; i++) begin
      op = {$urandom, $urandom, $urandom, $urandom};
      if (i % 5 == 0) op[127:64] = '0;
      sg = 1'($urandom_range(1, 0));
      start(op, sg);
      wait_done(lat, res);
      checks++;
      if (res !== ref_mod(op, sg) || lat != 130) begin
        errors++;
        $display("FAIL random[%0d]: op=%h sign=%b got %0d lat %0d, required %0d lat 130", i, op, sg, res, lat, ref_mod(op, sg));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort;
    logic [63:0] res;
    int          lat;
    int          early;
    early = 0;
    start(128'd12345, 1'b0);
    for (int n = 0; n < 39; n++) begin @(negedge clk); if (mod_done) early++; end
    start(128'd77, 1'b1);
    wait_done(lat, res);
    checks++;
    if (early != 0 || lat != 130) begin
      errors++; $display("FAIL abort_latency: early dones %0d lat %0d, required 0 and 130", early, lat);
    end
    checks++;
    if (res !== P - 64'd77) begin errors++; $display("FAIL abort_result: %0d, required %0d", res, P - 64'd77); end
    early = 0;
    for (int n = 0; n < 140; n++) begin @(negedge clk); if (mod_done) early++; end
    checks++;
    if (early != 0) begin errors++; $display("FAIL abort_extra_done: %0d extra pulses, required 0", early); end
  endtask

  task automatic test_reset_mid;
    logic [63:0] res;
    int          lat;
    int          stray;
    stray = 0;
    start({64'd0, P} + 128'd9, 1'b0);
    repeat (60) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (mod_done !== 1'b0 || mod_result !== 64'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid: done=%b result=%0d busy=%b, required 0/0/0", mod_done, mod_result, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int n = 0; n < 150; n++) begin @(negedge clk); if (mod_done || busy) stray++; end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL reset_stray: %0d active cycles, required 0", stray); end
    start(128'd1000, 1'b1);
    wait_done(lat, res);
    checks++;
    if (res !== P - 64'd1000 || lat != 130) begin
      errors++; $display("FAIL reset_restart: %0d lat %0d, required %0d lat 130", res, lat, P - 64'd1000);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [63:0] res;
    int          lat;
    start({64'd0, P} + 128'd42, 1'b0);
    wait_done(lat, res);
    start(128'd3, 1'b1);
    checks++;
    if (res !== 64'd42 || lat != 130) begin
      errors++; $display("FAIL b2b_first: %0d lat %0d, required 42 lat 130", res, lat);
    end
    wait_done(lat, res);
    checks++;
    if (res !== P - 64'd3 || lat != 130) begin
      errors++; $display("FAIL b2b_second: %0d lat %0d, required %0d lat 130", res, lat, P - 64'd3);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_abort;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
